// File: rtl/soc_ctrl_rst_seq_gen_if.sv
// ---------------------------------------------------------------------------
// soc_ctrl_rst_seq_gen_if
// Purpose : groups the per-channel request/release signals of the reset and
//           clock-enable sequencer into one bundle. The requester (SoC
//           control logic) uses the master modport. The sequencer uses the
//           slave modport.
// Signals : ch_arst_ni  [NUM_CH]       per-channel reset request, async, active-low
//           ch_clk_en_i [NUM_CH]       per-channel clock-enable request, async
//           delay_i     [NUM_CH*CNT_W] per-channel release delay, ch k at [k*CNT_W+:CNT_W]
//           seq_mode_i                 0 = parallel release, 1 = ascending sequential
//           ch_arst_no  [NUM_CH]       per-channel reset out, active-low
//           ch_clk_en_o [NUM_CH]       per-channel gated clock-enable
//           ch_ready_o  [NUM_CH]       channel has reached RUN
//           busy_o                     some requested channel is not yet in RUN
//           rel_cnt_o   [NUM_CH*8]     RELEASE entry counters. This signal exists
//                                      only when SOC_CTRL_RST_SEQ_STATUS_EN is
//                                      defined.
// ---------------------------------------------------------------------------
interface soc_ctrl_rst_seq_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);
   logic [NUM_CH-1:0]       ch_arst_ni;
   logic [NUM_CH-1:0]       ch_clk_en_i;
   logic [NUM_CH*CNT_W-1:0] delay_i;
   logic                    seq_mode_i;
   logic [NUM_CH-1:0]       ch_arst_no;
   logic [NUM_CH-1:0]       ch_clk_en_o;
   logic [NUM_CH-1:0]       ch_ready_o;
   logic                    busy_o;
`ifdef SOC_CTRL_RST_SEQ_STATUS_EN
   logic [NUM_CH*8-1:0]     rel_cnt_o;
`endif

   // The requester drives the requests and observes the sequencer outputs.
   modport master (
      output ch_arst_ni, ch_clk_en_i, delay_i, seq_mode_i,
`ifdef SOC_CTRL_RST_SEQ_STATUS_EN
      input  rel_cnt_o,
`endif
      input  ch_arst_no, ch_clk_en_o, ch_ready_o, busy_o
   );

   // The sequencer consumes the requests and drives the release outputs.
   modport slave (
      input  ch_arst_ni, ch_clk_en_i, delay_i, seq_mode_i,
`ifdef SOC_CTRL_RST_SEQ_STATUS_EN
      output rel_cnt_o,
`endif
      output ch_arst_no, ch_clk_en_o, ch_ready_o, busy_o
   );
endinterface

// File: rtl/soc_ctrl_rst_seq_gen.sv
// ---------------------------------------------------------------------------
// soc_ctrl_rst_seq_gen
// Purpose : multi-channel reset / clock-enable release sequencer running on
//           the always-on reference clock.
//           Each channel does the following:
//             1. It synchronises its reset request.
//             2. It waits for its turn. This applies only in sequential mode.
//             3. It counts a delay that is latched when the channel starts
//                counting.
//             4. It releases its reset.
//             5. It then passes its synchronised clock-enable through.
// Ports   : clk_i    reference clock (only clock of the block)
//           arst_ni  global reset, asynchronous, active-low
//           ctrlIf   soc_ctrl_rst_seq_gen_if.slave. This carries the
//                    per-channel requests, delays, mode and release outputs.
// Options : SOC_CTRL_RST_SEQ_STATUS_EN. When this macro is defined, the block
//           adds rel_cnt_o. rel_cnt_o holds one saturating 8-bit count of
//           RELEASE entries per channel. These counters are cleared only by
//           arst_ni.
// ---------------------------------------------------------------------------
module soc_ctrl_rst_seq_gen #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   soc_ctrl_rst_seq_gen_if.slave ctrlIf
);

   typedef enum logic [2:0] {
      ST_RESET,
      ST_WAIT,
      ST_COUNT,
      ST_RELEASE,
      ST_RUN
   } chState_e;

   logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_reqPipe;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_enPipe;
   logic [NUM_CH-1:0]                  w_reqSync;
   logic [NUM_CH-1:0]                  w_enSync;
   logic                               r_globalRel;
   logic                               r_seqMode;
   chState_e                           r_state     [NUM_CH];
   chState_e                           w_stateNext [NUM_CH];
   logic [CNT_W-1:0]                   r_cnt       [NUM_CH];
   logic [CNT_W-1:0]                   r_delay     [NUM_CH];
   logic [NUM_CH-1:0]                  r_arstN;
   logic [NUM_CH-1:0]                  r_clkEn;
   logic [NUM_CH-1:0]                  w_run;
   logic [NUM_CH-1:0]                  w_prevRun;
   logic [NUM_CH-1:0]                  w_arstOut;

   // Request and enable synchronisers.
   // Element [0] is the first flop of each chain.
   // Element [SYNC_STAGES-1] is the value the FSMs see.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_reqPipe <= '0;
         r_enPipe  <= '0;
      end else begin
         r_reqPipe <= {r_reqPipe[SYNC_STAGES-2:0], ctrlIf.ch_arst_ni};
         r_enPipe  <= {r_enPipe[SYNC_STAGES-2:0], ctrlIf.ch_clk_en_i};
      end
   end

   assign w_reqSync = r_reqPipe[SYNC_STAGES-1];
   assign w_enSync  = r_enPipe[SYNC_STAGES-1];

   // r_globalRel marks the first clock after the global reset is released.
   // While r_globalRel is 0, the release mode tracks seq_mode_i.
   // After that the mode is frozen, so the release ordering cannot change
   // underneath channels that are already counting.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_globalRel <= 1'b0;
      end else begin
         r_globalRel <= 1'b1;
      end
   end

   // This flop has no reset, because it must keep sampling while
   // arst_ni is held low.
   always_ff @(posedge clk_i) begin
      if (!r_globalRel) begin
         r_seqMode <= ctrlIf.seq_mode_i;
      end
   end

   // w_prevRun[k] is 1 when every lower-indexed channel is in RUN.
   // In sequential mode this gates the start of counting. It also makes
   // every higher channel fall back to WAIT on the same edge when any lower
   // channel drops out.
   always_comb begin : prevRunCalc
      logic chainOk;
      w_run     = '0;
      w_prevRun = '0;
      chainOk   = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         w_run[k]     = (r_state[k] == ST_RUN);
         w_prevRun[k] = chainOk;
         chainOk      = chainOk & w_run[k];
      end
   end

   // Per-channel next-state logic.
   // A synchronised request going low overrides every state.
   // In sequential mode, a broken chain below a channel sends it back to
   // WAIT from COUNT, RELEASE or RUN.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         w_stateNext[k] = r_state[k];
         if (!w_reqSync[k]) begin
            w_stateNext[k] = ST_RESET;
         end else begin
            unique case (r_state[k])
               ST_RESET: w_stateNext[k] = ST_WAIT;
               ST_WAIT: begin
                  if (!r_seqMode || w_prevRun[k]) w_stateNext[k] = ST_COUNT;
               end
               ST_COUNT: begin
                  if (r_seqMode && !w_prevRun[k])  w_stateNext[k] = ST_WAIT;
                  else if (r_cnt[k] == r_delay[k]) w_stateNext[k] = ST_RELEASE;
               end
               ST_RELEASE: begin
                  if (r_seqMode && !w_prevRun[k]) w_stateNext[k] = ST_WAIT;
                  else                            w_stateNext[k] = ST_RUN;
               end
               ST_RUN: begin
                  if (r_seqMode && !w_prevRun[k]) w_stateNext[k] = ST_WAIT;
               end
               default: w_stateNext[k] = ST_RESET;
            endcase
         end
      end
   end

   // State, counter and registered output update.
   // The delay is latched only on the edge from WAIT to COUNT.
   // The counter is zero whenever the channel is not counting, so a
   // restarted channel always counts its full delay again.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_state[k] <= ST_RESET;
            r_cnt[k]   <= '0;
            r_delay[k] <= '0;
         end
         r_arstN <= '0;
         r_clkEn <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_state[k] <= w_stateNext[k];
            r_arstN[k] <= (w_stateNext[k] == ST_RELEASE) || (w_stateNext[k] == ST_RUN);
            r_clkEn[k] <= (w_stateNext[k] == ST_RUN) && w_enSync[k];
            if ((r_state[k] == ST_WAIT) && (w_stateNext[k] == ST_COUNT)) begin
               r_cnt[k]   <= '0;
               r_delay[k] <= ctrlIf.delay_i[k*CNT_W +: CNT_W];
            end else if (w_stateNext[k] == ST_COUNT) begin
               r_cnt[k] <= r_cnt[k] + 1'b1;
            end else begin
               r_cnt[k] <= '0;
            end
         end
      end
   end

   // The reset outputs assert asynchronously from either reset input.
   // They are released only by the registered release bit.
   // The clock-enable is masked by the same combined reset, so it can
   // never be high while its channel is held in reset.
   assign w_arstOut          = r_arstN & ctrlIf.ch_arst_ni & {NUM_CH{arst_ni}};
   assign ctrlIf.ch_arst_no  = w_arstOut;
   assign ctrlIf.ch_clk_en_o = r_clkEn & w_arstOut;
   assign ctrlIf.ch_ready_o  = w_run;
   assign ctrlIf.busy_o      = |(w_reqSync & ~w_run);

`ifdef SOC_CTRL_RST_SEQ_STATUS_EN
   logic [NUM_CH-1:0][7:0] r_relCnt;

   // Each counter counts entries into RELEASE and saturates at 255.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_relCnt <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if ((w_stateNext[k] == ST_RELEASE) && (r_state[k] != ST_RELEASE) &&
                (r_relCnt[k] != 8'hFF)) begin
               r_relCnt[k] <= r_relCnt[k] + 8'd1;
            end
         end
      end
   end

   assign ctrlIf.rel_cnt_o = r_relCnt;
`endif

endmodule
